switch_judge: RTL and testbench

- Player-input end of the LED target path: watches the 16 slide switches, judges each toggle against the LED currently lit for the active timer step, and keeps the score.
- Sits between the switch pins and the score/seven-segment logic; consumes the same 6-bit timer value and 16-bit LED pattern that drive the board LEDs.
- One judgement per timer step.

---
 rtl/switch_judge_if.sv | 25 ++
 rtl/switch_judge.sv | 123 ++++++++++++
 tb/tb_switch_judge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/switch_judge_if.sv
// Signal bundle between the board I/O (timer, LED pattern, switches) and the switch judge.
// The judge uses the slave modport; whatever drives the game uses master.
interface switch_judge_if #(
  parameter int NUM_SW  = 16,
  parameter int SCORE_W = 6
);
  logic [5:0]         timer_in;
  logic [NUM_SW-1:0]  led_in;
  logic [NUM_SW-1:0]  sw;
  logic [SCORE_W-1:0] score_out;
  logic [SCORE_W-1:0] miss_out;
  logic               hit;
  logic               miss;
  logic               game_over;

  modport slave (
    input  timer_in, led_in, sw,
    output score_out, miss_out, hit, miss, game_over
  );

  modport master (
    output timer_in, led_in, sw,
    input  score_out, miss_out, hit, miss, game_over
  );
endinterface

// File: rtl/switch_judge.sv
// Judges one switch toggle per timer window against the lit LED and keeps hit/miss scores.
// Optional SWITCH_JUDGE_MISS_PENALTY_EN: each miss also decrements the score, floored at 0.
module switch_judge #(
  parameter int NUM_SW    = 16,
  parameter int SCORE_W   = 6,
  parameter int SCORE_MAX = 63
) (
  input  logic           clk,
  input  logic           rst,
  switch_judge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, DONE} state_t;

  localparam logic [SCORE_W-1:0] CNT_MAX = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] CNT_ONE = SCORE_W'(1);

  state_t             state_q, state_d;
  logic [NUM_SW-1:0]  sync1_q, sw_s_q, sw_prev_q;
  logic [NUM_SW-1:0]  target_q, target_d;
  logic [5:0]         timer_prev_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_cnt_q, miss_cnt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic [NUM_SW-1:0]  toggle;
  logic               tchg;
  logic               timer_zero;

  assign toggle     = sw_s_q ^ sw_prev_q;
  assign tchg       = (bus.timer_in != timer_prev_q);
  assign timer_zero = (bus.timer_in == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sw_s_q       <= '0;
      sw_prev_q    <= '0;
      timer_prev_q <= '0;
      target_q     <= '0;
      state_q      <= IDLE;
      score_q      <= '0;
      miss_cnt_q   <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      sync1_q      <= bus.sw;
      sw_s_q       <= sync1_q;
      sw_prev_q    <= sw_s_q;
      timer_prev_q <= bus.timer_in;
      target_q     <= target_d;
      state_q      <= state_d;
      score_q      <= score_d;
      miss_cnt_q   <= miss_cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    if (tchg && !timer_zero) begin
      target_d = bus.led_in;
    end

    case (state_q)
      IDLE: begin
        if (tchg && !timer_zero) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A timer change in the same cycle as a toggle discards the toggle.
        if (tchg) begin
          state_d = timer_zero ? DONE : ARMED;
        end else if (toggle != '0) begin
          state_d = LOCKED;
          if (((toggle & target_q) != '0) && ((toggle & ~target_q) == '0)) begin
            hit_d = 1'b1;
            if (score_q != CNT_MAX) begin
              score_d = score_q + CNT_ONE;
            end
          end else begin
            miss_d = 1'b1;
            if (miss_cnt_q != CNT_MAX) begin
              miss_cnt_d = miss_cnt_q + CNT_ONE;
            end
`ifdef SWITCH_JUDGE_MISS_PENALTY_EN
            if (score_q != '0) begin
              score_d = score_q - CNT_ONE;
            end
`endif
          end
        end
      end
      LOCKED: begin
        if (tchg) begin
          state_d = timer_zero ? DONE : ARMED;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.score_out = score_q;
  assign bus.miss_out  = miss_cnt_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.game_over = (state_q == DONE);

endmodule

// File: tb/tb_switch_judge.sv
// Directed bench for switch_judge: latency, hit/miss rules, tchg priority, saturation, game over.
module tb_switch_judge;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulses;
  int   exp_score;
  logic [15:0] sw_v;

  switch_judge_if #(.NUM_SW(16), .SCORE_W(6)) bus ();

  switch_judge #(.NUM_SW(16), .SCORE_W(6), .SCORE_MAX(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input logic [5:0] t, input logic [15:0] led);
    bus.timer_in = t;
    bus.led_in   = led;
  endtask

  task automatic flip(input logic [15:0] mask);
    sw_v   = sw_v ^ mask;
    bus.sw = sw_v;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    sw_v      = 16'hFFFF;
    bus.sw    = sw_v;
    set_window(6'd0, 16'h0000);
    repeat (3) tick();

    check("rst_score", 32'(bus.score_out), 0);
    check("rst_miss_cnt", 32'(bus.miss_out), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_miss", 32'(bus.miss), 0);
    check("rst_game_over", 32'(bus.game_over), 0);

    // Switches already up at reset must not be judged while idle.
    rst    = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.hit || bus.miss) pulses++;
    end
    check("idle_no_pulse", 32'(pulses), 0);
    check("idle_score", 32'(bus.score_out), 0);

    // Correct toggle: exact 3-edge latency, one-cycle pulse.
    set_window(6'd30, 16'h2000); tick();
    set_window(6'd29, 16'h2000); tick();
    flip(16'h2000);
    tick(); check("hit_lat_e1", 32'(bus.hit), 0);
    tick(); check("hit_lat_e2", 32'(bus.hit), 0);
    tick(); check("hit_lat_e3", 32'(bus.hit), 1);
    check("hit_no_miss", 32'(bus.miss), 0);
    check("hit_score", 32'(bus.score_out), 1);
    tick(); check("hit_one_cycle", 32'(bus.hit), 0);

    // Second toggle in the same window is ignored.
    flip(16'h2000);
    pulses = 0;
    repeat (5) begin
      tick();
      if (bus.hit || bus.miss) pulses++;
    end
    check("locked_no_pulse", 32'(pulses), 0);
    check("locked_score", 32'(bus.score_out), 1);

    // Wrong switch.
`ifdef SWITCH_JUDGE_MISS_PENALTY_EN
    exp_score = 0;
`else
    exp_score = 1;
`endif
    set_window(6'd28, 16'h0080); tick();
    flip(16'h0001);
    repeat (3) tick();
    check("wrong_miss", 32'(bus.miss), 1);
    check("wrong_no_hit", 32'(bus.hit), 0);
    check("wrong_miss_cnt", 32'(bus.miss_out), 1);
    check("wrong_score", 32'(bus.score_out), 32'(exp_score));

    // Right plus wrong bit in the same cycle is a miss.
    set_window(6'd27, 16'h0080); tick();
    flip(16'h0088);
    repeat (3) tick();
    check("mixed_miss", 32'(bus.miss), 1);
    check("mixed_no_hit", 32'(bus.hit), 0);
    check("mixed_miss_cnt", 32'(bus.miss_out), 2);
    check("mixed_score", 32'(bus.score_out), 32'(exp_score));

    // Toggle arriving in the same cycle as a timer change is discarded.
    set_window(6'd26, 16'h0080); tick();
    flip(16'h0080);
    tick(); tick();
    set_window(6'd25, 16'h0080);
    tick();
    check("coll_hit_e3", 32'(bus.hit), 0);
    check("coll_miss_e3", 32'(bus.miss), 0);
    tick();
    check("coll_hit_e4", 32'(bus.hit), 0);
    check("coll_miss_e4", 32'(bus.miss), 0);
    // The new window is still open.
    flip(16'h0080);
    repeat (3) tick();
    exp_score = exp_score + 1;
    check("after_coll_hit", 32'(bus.hit), 1);
    check("after_coll_score", 32'(bus.score_out), 32'(exp_score));

    // Blank target: any toggle is a miss.
`ifdef SWITCH_JUDGE_MISS_PENALTY_EN
    exp_score = 0;
`endif
    set_window(6'd24, 16'h0000); tick();
    flip(16'h0020);
    repeat (3) tick();
    check("blank_miss", 32'(bus.miss), 1);
    check("blank_miss_cnt", 32'(bus.miss_out), 3);
    check("blank_score", 32'(bus.score_out), 32'(exp_score));

    // 64 consecutive correct windows: score saturates at 63, hit keeps pulsing.
    for (int i = 0; i < 64; i++) begin
      logic [15:0] m;
      m = 16'h0001 << (i % 16);
      set_window((i % 2 == 0) ? 6'd40 : 6'd41, m); tick();
      flip(m);
      repeat (3) tick();
      exp_score = (exp_score < 63) ? exp_score + 1 : 63;
      check($sformatf("sat_hit_%0d", i), 32'(bus.hit), 1);
      check($sformatf("sat_score_%0d", i), 32'(bus.score_out), 32'(exp_score));
    end
    check("sat_final_score", 32'(bus.score_out), 63);

    // Timer reaching zero ends the game; everything freezes.
    set_window(6'd0, 16'h0000);
    tick();
    check("done_game_over", 32'(bus.game_over), 1);
    flip(16'h0002);
    set_window(6'd20, 16'hFFFF);
    pulses = 0;
    repeat (6) begin
      tick();
      if (bus.hit || bus.miss) pulses++;
    end
    check("done_no_pulse", 32'(pulses), 0);
    check("done_score", 32'(bus.score_out), 63);
    check("done_miss_cnt", 32'(bus.miss_out), 3);
    check("done_still_over", 32'(bus.game_over), 1);

    // Reset mid-game takes effect without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_score", 32'(bus.score_out), 0);
    check("arst_miss_cnt", 32'(bus.miss_out), 0);
    check("arst_game_over", 32'(bus.game_over), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
